display_sequencer: RTL
======================

// Module: display_sequencer
// PURPOSE
//  Parametrised, registered successor to the combinational display mapper. Sits between the game FSM and
//  the 7-seg multiplex driver: turns current_state + bulls/cows into an N_DIGITS glyph bus.
//  Adds a tick prescaler, a timed result hold with a done pulse, snapshotting of scores, and optional WIN blink.
// PARAMETERS
//  N_DIGITS    8     digits driven; >= 8, elaboration error otherwise; digits beyond 8 are blank
//  TICK_DIV    50000 clock cycles per tick (>= 2)
//  HOLD_TICKS  2000  ticks a DISPLAY_RESULT_* message is held before msg_done
//  BLINK_TICKS 250   ticks per WIN blink half-period (used only with DISP_BLINK_EN)
// PORTS
//  clock          in   1            system clock
//  reset          in   1            synchronous, active-high reset
//  current_state  in   state_t(3)   game FSM state
//  bulls          in   4            bulls count, sampled on a state change
//  cows           in   4            cows count, sampled on a state change
//  digits         out  6*N_DIGITS   glyph bus; digit k (1 = leftmost) at [6*k-1 -: 6]
//  msg_done       out  1            one-cycle pulse when the result hold expires
//  busy           out  1            high while a result hold is counting
// BEHAVIOUR
//  Reset: all digits = GLY_BLANK (6'b100000), msg_done = 0, busy = 0, all counters = 0,
//   prev_state = invalid sentinel, so the first post-reset cycle always counts as a state change.
//  Prescaler: tick_cnt counts 0..TICK_DIV-1; tick is high for one cycle on wrap. Cleared on every load.
//  Load: when current_state != prev_state, latch bulls/cows into snapshots and clear the hold and blink counters.
//   digits then show the new message on the next cycle (1-cycle latency).
//  Display FSM:
//   BLANK -> SHOW on load.
//   SHOW, result state -> HOLD (busy = 1).
//   HOLD counts ticks; on tick HOLD_TICKS -> DONE, with msg_done pulsed for exactly one cycle and busy = 0.
//   DONE keeps the message steady until the next load.
//   Any load from any state -> SHOW.
//  Messages (d1..d8):
//   SECRET_Jn  "Jn SETUP"
//   GUESS_Jn   "Jn GUESS"
//   RESULT     "<b> TO<c> VA"
//   WIN        "BULLSEYE"
//   FIM        "  FIM   "
//  Numeric glyph for v in 0..9 = {2'b00, v}; v > 9 shows GLY_DASH.
//  Simultaneous load and hold expiry: the load wins; no msg_done.
//  bulls/cows changing without a state change does not alter the display (snapshot only).
//  HOLD_TICKS = 0 is treated as 1.
//  Reset asserted mid-hold: blank the display on the next cycle; no msg_done.
// CONFIGURATION
//  `DISP_BLINK_EN defined: in WIN, all digits alternate message/blank every BLINK_TICKS ticks, starting with
//   the message visible after the load.
//  Undefined: WIN is shown steady; the blink counter and BLINK_TICKS are unused.
// STRUCTURE
//  Package disp_pkg holds:
//   - state_t
//   - glyph constants: GLY_BLANK 100000, J 001011, S 000101, E 001110, T 000111, U 001100, P 001101,
//     G 000110, O 000000, A 001010, B 001000, L 001001, Y 000100, F 010000, I 010001, M 010010, DASH 010011
//   - function num_glyph(v)
//  One sub-module, disp_tick_gen (the prescaler: clock, reset, clr, tick).
//  The message ROM and FSM stay in the top.
// TESTING (TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2, N_DIGITS=10)
//  1. Reset held 3 cycles, then released with state=SECRET_J1 -> digits blank during reset;
//     "J1 SETUP" with d9,d10 blank one cycle after release.
//  2. DISPLAY_RESULT_J2, bulls=2, cows=1 -> "2 TO1 VA", busy=1; msg_done pulses once exactly 12 cycles after
//     the load; busy=0 after.
//  3. In RESULT, change bulls to 4 with no state change -> d1 stays 2. bulls=12 on load -> d1 = GLY_DASH.
//  4. State change on the same cycle the hold expires -> no msg_done; the new message appears next cycle.
//  5. Reset mid-hold (tick 2) -> blank next cycle, msg_done never asserted.
//  6. WIN with DISP_BLINK_EN -> message 8 cycles, blank 8 cycles, repeating.
//     Without the macro -> steady "BULLSEYE".

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types, glyph codes and the numeric glyph helper for the display sequencer.
package disp_pkg;

  typedef enum logic [2:0] {
    SECRET_J1         = 3'd0,
    SECRET_J2         = 3'd1,
    GUESS_J1          = 3'd2,
    GUESS_J2          = 3'd3,
    DISPLAY_RESULT_J1 = 3'd4,
    DISPLAY_RESULT_J2 = 3'd5,
    WIN               = 3'd6,
    FIM               = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    D_BLANK,
    D_SHOW,
    D_HOLD,
    D_DONE
  } disp_fsm_t;

  localparam logic [5:0] GLY_BLANK = 6'b100000;
  localparam logic [5:0] GLY_J     = 6'b001011;
  localparam logic [5:0] GLY_S     = 6'b000101;
  localparam logic [5:0] GLY_E     = 6'b001110;
  localparam logic [5:0] GLY_T     = 6'b000111;
  localparam logic [5:0] GLY_U     = 6'b001100;
  localparam logic [5:0] GLY_P     = 6'b001101;
  localparam logic [5:0] GLY_G     = 6'b000110;
  localparam logic [5:0] GLY_O     = 6'b000000;
  localparam logic [5:0] GLY_A     = 6'b001010;
  localparam logic [5:0] GLY_B     = 6'b001000;
  localparam logic [5:0] GLY_L     = 6'b001001;
  localparam logic [5:0] GLY_Y     = 6'b000100;
  localparam logic [5:0] GLY_F     = 6'b010000;
  localparam logic [5:0] GLY_I     = 6'b010001;
  localparam logic [5:0] GLY_M     = 6'b010010;
  localparam logic [5:0] GLY_DASH  = 6'b010011;

  function automatic logic [5:0] num_glyph(input logic [3:0] v);
    return (v > 4'd9) ? GLY_DASH : {2'b00, v};
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr.
module disp_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/display_sequencer.sv
// Registered game-state to glyph-bus sequencer with timed result hold and done pulse.
// Optional WIN blinking is enabled by defining DISP_BLINK_EN.
module display_sequencer
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic                    clock,
  input  logic                    reset,
  input  state_t                  current_state,
  input  logic [3:0]              bulls,
  input  logic [3:0]              cows,
  output logic [6*N_DIGITS-1:0]   digits,
  output logic                    msg_done,
  output logic                    busy
);

  localparam int unsigned HOLD_EFF = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
  localparam int unsigned HW = $clog2(HOLD_EFF + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_EFF - 1);

  if (N_DIGITS < 8) begin : g_bad_n_digits
    $error("display_sequencer: N_DIGITS must be >= 8");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("display_sequencer: TICK_DIV must be >= 2");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink_ticks
    $error("display_sequencer: BLINK_TICKS must be >= 1");
  end

  // d1 sits in the low six bits; "V" is drawn with the U glyph.
  function automatic logic [47:0] msg_rom(input state_t s, input logic [3:0] b,
                                          input logic [3:0] c);
    logic [5:0] n;
    n = (s == SECRET_J2 || s == GUESS_J2) ? num_glyph(4'd2) : num_glyph(4'd1);
    case (s)
      SECRET_J1, SECRET_J2:
        msg_rom = {GLY_P, GLY_U, GLY_T, GLY_E, GLY_S, GLY_BLANK, n, GLY_J};
      GUESS_J1, GUESS_J2:
        msg_rom = {GLY_S, GLY_S, GLY_E, GLY_U, GLY_G, GLY_BLANK, n, GLY_J};
      DISPLAY_RESULT_J1, DISPLAY_RESULT_J2:
        msg_rom = {GLY_A, GLY_U, GLY_BLANK, num_glyph(c), GLY_O, GLY_T, GLY_BLANK, num_glyph(b)};
      WIN:
        msg_rom = {GLY_E, GLY_Y, GLY_E, GLY_S, GLY_L, GLY_L, GLY_U, GLY_B};
      FIM:
        msg_rom = {GLY_BLANK, GLY_BLANK, GLY_BLANK, GLY_M, GLY_I, GLY_F, GLY_BLANK, GLY_BLANK};
      default:
        msg_rom = {8{GLY_BLANK}};
    endcase
  endfunction

  state_t               prev_state;
  logic                 prev_valid;
  logic [3:0]           snap_bulls;
  logic [3:0]           snap_cows;
  disp_fsm_t            fsm;
  logic [HW-1:0]        hold_cnt;
  logic                 tick;
  logic                 load;
  logic                 blank_nxt;
  state_t               eff_state;
  logic [3:0]           eff_bulls;
  logic [3:0]           eff_cows;
  logic [47:0]          rom;
  logic [6*N_DIGITS-1:0] digits_nxt;

  // prev_valid stands in for an out-of-range sentinel: all eight state codes are in use.
  assign load = !prev_valid || (current_state != prev_state);

  disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (load),
    .tick  (tick)
  );

`ifdef DISP_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic          blink_flip;

  assign blink_flip = !load && (prev_state == WIN) && tick && (blink_cnt == BLINK_LAST);
  // Digits use the post-flip phase so each half-period is exactly BLINK_TICKS ticks long.
  assign blank_nxt  = load ? 1'b0 : (blink_off ^ blink_flip);

  always_ff @(posedge clock) begin
    if (reset || load) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (prev_state == WIN && tick) begin
      blink_cnt <= blink_flip ? '0 : blink_cnt + BW'(1);
      blink_off <= blank_nxt;
    end
  end
`else
  assign blank_nxt = 1'b0;
`endif

  always_comb begin
    eff_state  = load ? current_state : prev_state;
    eff_bulls  = load ? bulls : snap_bulls;
    eff_cows   = load ? cows : snap_cows;
    rom        = msg_rom(eff_state, eff_bulls, eff_cows);
    digits_nxt = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      digits_nxt[6*k +: 6] = blank_nxt ? GLY_BLANK : rom[6*k +: 6];
    end
    for (int unsigned k = 8; k < N_DIGITS; k++) begin
      digits_nxt[6*k +: 6] = GLY_BLANK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_state <= SECRET_J1;
      prev_valid <= 1'b0;
      snap_bulls <= '0;
      snap_cows  <= '0;
      fsm        <= D_BLANK;
      hold_cnt   <= '0;
      digits     <= {N_DIGITS{GLY_BLANK}};
      msg_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      prev_state <= current_state;
      prev_valid <= 1'b1;
      digits     <= digits_nxt;
      msg_done   <= 1'b0;
      if (load) begin
        snap_bulls <= bulls;
        snap_cows  <= cows;
        hold_cnt   <= '0;
        fsm        <= D_SHOW;
        busy       <= 1'b0;
      end else begin
        case (fsm)
          D_SHOW: begin
            if (prev_state == DISPLAY_RESULT_J1 || prev_state == DISPLAY_RESULT_J2) begin
              fsm  <= D_HOLD;
              busy <= 1'b1;
            end
          end
          D_HOLD: begin
            if (tick) begin
              if (hold_cnt == HOLD_LAST) begin
                fsm      <= D_DONE;
                msg_done <= 1'b1;
                busy     <= 1'b0;
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
